// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2/memory port between icache read, dcache read
// and dcache write-back. Grant is held for a whole burst; data beats pass through.
module l2_port_arbiter #(
  parameter int B = 9,
  parameter int W = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                INS_ADDR_VALID,
  output logic                INS_ADDR_READY,
  input  logic [29:0]         INS_ADDR,
  output logic                INS_DATA_VALID,
  input  logic                INS_DATA_READY,
  output logic [(1<<W)-1:0]   INS_DATA,
  input  logic                DAT_RD_ADDR_VALID,
  output logic                DAT_RD_ADDR_READY,
  input  logic [29:0]         DAT_RD_ADDR,
  output logic                DAT_DATA_VALID,
  input  logic                DAT_DATA_READY,
  output logic [(1<<W)-1:0]   DAT_DATA,
  input  logic                DAT_WR_VALID,
  output logic                DAT_WR_READY,
  input  logic [29:0]         DAT_WR_ADDR,
  input  logic [(1<<W)-1:0]   DAT_WR_DATA,
  output logic                DAT_WR_COMPLETE,
  output logic                MEM_ADDR_VALID,
  input  logic                MEM_ADDR_READY,
  output logic [29:0]         MEM_ADDR,
  output logic                MEM_WE,
  output logic                MEM_WDATA_VALID,
  input  logic                MEM_WDATA_READY,
  output logic [(1<<W)-1:0]   MEM_WDATA,
  input  logic                MEM_RDATA_VALID,
  output logic                MEM_RDATA_READY,
  input  logic [(1<<W)-1:0]   MEM_RDATA,
  input  logic                MEM_WR_DONE
);
  localparam int L2_BURST = 1 << (B - W);
  localparam int CNT_W    = ((B - W) > 1) ? (B - W) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, RD_DATA, WR_DATA, WR_WAIT} state_t;

  state_t           state, state_nx;
  logic [1:0]       owner, last, pick, p0, p1, p2;
  logic [2:0]       req;
  logic             grant, beat, last_beat, rd_beat, wr_beat;
  logic [29:0]      grant_addr, mem_addr_q;
  logic             mem_we_q, wr_complete_q;
  logic [CNT_W-1:0] cnt;

  assign req = {DAT_WR_VALID, DAT_RD_ADDR_VALID, INS_ADDR_VALID};

  // Search order starts one past the most recent winner.
  always_comb begin
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (req[p0])      pick = p0;
    else if (req[p1]) pick = p1;
    else              pick = p2;
    grant = (state == IDLE) && (|req) && !RST;
    case (pick)
      2'd0:    grant_addr = INS_ADDR;
      2'd1:    grant_addr = DAT_RD_ADDR;
      default: grant_addr = DAT_WR_ADDR;
    endcase
  end

  assign rd_beat   = MEM_RDATA_VALID && ((owner == 2'd0) ? INS_DATA_READY : DAT_DATA_READY);
  assign wr_beat   = DAT_WR_VALID && MEM_WDATA_READY;
  assign beat      = ((state == RD_DATA) && rd_beat) || ((state == WR_DATA) && wr_beat);
  assign last_beat = beat && (cnt == CNT_W'(L2_BURST - 1));

  assign INS_DATA        = MEM_RDATA;
  assign DAT_DATA        = MEM_RDATA;
  assign MEM_WDATA       = DAT_WR_DATA;
  assign MEM_ADDR        = mem_addr_q;
  assign MEM_WE          = mem_we_q;
  assign DAT_WR_COMPLETE = wr_complete_q;

  always_comb begin
    // NOTE: every output and the next state get a default first, so no latch is inferred.
    state_nx          = state;
    INS_ADDR_READY    = 1'b0;
    DAT_RD_ADDR_READY = 1'b0;
    INS_DATA_VALID    = 1'b0;
    DAT_DATA_VALID    = 1'b0;
    DAT_WR_READY      = 1'b0;
    MEM_ADDR_VALID    = 1'b0;
    MEM_WDATA_VALID   = 1'b0;
    MEM_RDATA_READY   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          INS_ADDR_READY    = (pick == 2'd0);
          DAT_RD_ADDR_READY = (pick == 2'd1);
          state_nx          = ADDR;
        end
      end
      ADDR: begin
        MEM_ADDR_VALID = 1'b1;
        if (MEM_ADDR_READY) state_nx = mem_we_q ? WR_DATA : RD_DATA;
      end
      RD_DATA: begin
        if (owner == 2'd0) begin
          INS_DATA_VALID  = MEM_RDATA_VALID;
          MEM_RDATA_READY = INS_DATA_READY;
        end else begin
          DAT_DATA_VALID  = MEM_RDATA_VALID;
          MEM_RDATA_READY = DAT_DATA_READY;
        end
        if (last_beat) state_nx = IDLE;
      end
      WR_DATA: begin
        MEM_WDATA_VALID = DAT_WR_VALID;
        DAT_WR_READY    = MEM_WDATA_READY;
        if (last_beat) state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        if (MEM_WR_DONE) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      owner         <= 2'd0;
      last          <= 2'd2;
      cnt           <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      wr_complete_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
      state         <= state_nx;
      wr_complete_q <= (state == WR_WAIT) && MEM_WR_DONE;
      if (grant) begin
        owner      <= pick;
        last       <= pick;
        mem_addr_q <= grant_addr;
        mem_we_q   <= (pick == 2'd2);
      end
      if ((state == ADDR) && MEM_ADDR_READY) cnt <= '0;
      else if (beat)                         cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench: a transaction-level model (round-robin pick, queued requests,
// beat counting) drives randomized traffic and memory responses against the arbiter.
module tb_l2_port_arbiter;
  localparam int DW    = 128;
  localparam int BURST = 4;

  logic CLK = 1'b0, RST = 1'b1;
  logic INS_ADDR_VALID, INS_ADDR_READY, INS_DATA_VALID, INS_DATA_READY;
  logic [29:0] INS_ADDR, DAT_RD_ADDR, DAT_WR_ADDR, MEM_ADDR;
  logic [DW-1:0] INS_DATA, DAT_DATA, DAT_WR_DATA, MEM_WDATA, MEM_RDATA;
  logic DAT_RD_ADDR_VALID, DAT_RD_ADDR_READY, DAT_DATA_VALID, DAT_DATA_READY;
  logic DAT_WR_VALID, DAT_WR_READY, DAT_WR_COMPLETE;
  logic MEM_ADDR_VALID, MEM_ADDR_READY, MEM_WE, MEM_WDATA_VALID, MEM_WDATA_READY;
  logic MEM_RDATA_VALID, MEM_RDATA_READY, MEM_WR_DONE;

  int checks = 0, failures = 0;
  int model_last = 2;
  logic [2:0] pending;
  logic [29:0] paddr [3];
  logic [DW-1:0] wdata [BURST];

  l2_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .INS_ADDR_VALID(INS_ADDR_VALID), .INS_ADDR_READY(INS_ADDR_READY), .INS_ADDR(INS_ADDR),
    .INS_DATA_VALID(INS_DATA_VALID), .INS_DATA_READY(INS_DATA_READY), .INS_DATA(INS_DATA),
    .DAT_RD_ADDR_VALID(DAT_RD_ADDR_VALID), .DAT_RD_ADDR_READY(DAT_RD_ADDR_READY),
    .DAT_RD_ADDR(DAT_RD_ADDR), .DAT_DATA_VALID(DAT_DATA_VALID),
    .DAT_DATA_READY(DAT_DATA_READY), .DAT_DATA(DAT_DATA),
    .DAT_WR_VALID(DAT_WR_VALID), .DAT_WR_READY(DAT_WR_READY), .DAT_WR_ADDR(DAT_WR_ADDR),
    .DAT_WR_DATA(DAT_WR_DATA), .DAT_WR_COMPLETE(DAT_WR_COMPLETE),
    .MEM_ADDR_VALID(MEM_ADDR_VALID), .MEM_ADDR_READY(MEM_ADDR_READY), .MEM_ADDR(MEM_ADDR),
    .MEM_WE(MEM_WE), .MEM_WDATA_VALID(MEM_WDATA_VALID), .MEM_WDATA_READY(MEM_WDATA_READY),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA_VALID(MEM_RDATA_VALID),
    .MEM_RDATA_READY(MEM_RDATA_READY), .MEM_RDATA(MEM_RDATA), .MEM_WR_DONE(MEM_WR_DONE)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin winner: first pending index searching from last+1 modulo 3.
  function automatic int rr_pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (model_last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    INS_ADDR_VALID = 0; INS_ADDR = '0; INS_DATA_READY = 0;
    DAT_RD_ADDR_VALID = 0; DAT_RD_ADDR = '0; DAT_DATA_READY = 0;
    DAT_WR_VALID = 0; DAT_WR_ADDR = '0; DAT_WR_DATA = '0;
    MEM_ADDR_READY = 0; MEM_WDATA_READY = 0; MEM_RDATA_VALID = 0; MEM_RDATA = '0;
    MEM_WR_DONE = 0;
  endtask

  task automatic drive_requests();
    INS_ADDR_VALID = pending[0]; INS_ADDR = paddr[0];
    DAT_RD_ADDR_VALID = pending[1]; DAT_RD_ADDR = paddr[1];
    DAT_WR_VALID = pending[2]; DAT_WR_ADDR = paddr[2]; DAT_WR_DATA = wdata[0];
  endtask

  task automatic apply_reset();
    tick();
    RST = 1; clear_inputs(); pending = '0; model_last = 2;
    tick(); tick();
    RST = 0;
  endtask

  // One complete transaction; entered and left in a cycle where the arbiter is IDLE.
  // bp: 0 none, 1 random, 2 write-ready toggles, 3 read-ready low 3 cycles after beat 2.
  task automatic run_txn(input logic [2:0] newreq, input int bp, input int stall, output int w);
    int beats, cyc, hold, extra;
    logic mv, rd;
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++)
      if (newreq[i] && !pending[i]) begin
        pending[i] = 1'b1;
        paddr[i] = 30'($urandom);
        if (i == 2) for (int b = 0; b < BURST; b++) wdata[b] = rand_beat();
      end
    w = rr_pick(pending);
    if (w < 0) begin tick(); return; end
    drive_requests();
    MEM_RDATA_VALID = 0; MEM_WR_DONE = 1'($urandom); MEM_ADDR_READY = 1'($urandom);
    #1;
    checks++; if (INS_ADDR_READY !== (w == 0)) begin failures++; $display("FAIL grant_ins got=%0b exp=%0b", INS_ADDR_READY, w == 0); end
    checks++; if (DAT_RD_ADDR_READY !== (w == 1)) begin failures++; $display("FAIL grant_drd got=%0b exp=%0b", DAT_RD_ADDR_READY, w == 1); end
    checks++; if ({DAT_WR_READY, MEM_ADDR_VALID} !== 2'b00) begin failures++; $display("FAIL idle_outputs got=%b exp=00", {DAT_WR_READY, MEM_ADDR_VALID}); end
    model_last = w;
    if (w != 2) pending[w] = 1'b0;
    tick();
    drive_requests(); MEM_WDATA_READY = 0;
    for (int s = 0; s <= stall; s++) begin
      MEM_ADDR_READY = (s == stall); MEM_WR_DONE = 1'($urandom);
      #1;
      checks++; if (MEM_ADDR_VALID !== 1'b1) begin failures++; $display("FAIL addr_valid got=%0b exp=1", MEM_ADDR_VALID); end
      checks++; if (MEM_ADDR !== paddr[w]) begin failures++; $display("FAIL mem_addr got=%0h exp=%0h", MEM_ADDR, paddr[w]); end
      checks++; if (MEM_WE !== (w == 2)) begin failures++; $display("FAIL mem_we got=%0b exp=%0b", MEM_WE, w == 2); end
      checks++; if ({INS_ADDR_READY, DAT_RD_ADDR_READY, DAT_WR_READY, MEM_WDATA_VALID, MEM_RDATA_READY, DAT_WR_COMPLETE} !== 6'b0)
        begin failures++; $display("FAIL addr_phase_quiet got=%b exp=000000", {INS_ADDR_READY, DAT_RD_ADDR_READY, DAT_WR_READY, MEM_WDATA_VALID, MEM_RDATA_READY, DAT_WR_COMPLETE}); end
      tick();
    end
    MEM_ADDR_READY = 0;
    beats = 0; cyc = 0; hold = 0;
    if (w != 2) begin
      while (beats < BURST && cyc < 200) begin
        mv = (bp == 1) ? 1'($urandom) : 1'b1;
        rd = (bp == 1) ? 1'($urandom) : 1'b1;
        if (bp == 3 && beats == 2 && hold < 3) begin rd = 1'b0; hold++; end
        d = rand_beat();
        MEM_RDATA = d; MEM_RDATA_VALID = mv; MEM_WR_DONE = 1'($urandom);
        if (w == 0) begin INS_DATA_READY = rd; DAT_DATA_READY = 1'($urandom); end
        else        begin DAT_DATA_READY = rd; INS_DATA_READY = 1'($urandom); end
        #1;
        checks++; if ((w == 0 ? INS_DATA_VALID : DAT_DATA_VALID) !== mv) begin failures++; $display("FAIL owner_valid beat=%0d got=%0b exp=%0b", beats, w == 0 ? INS_DATA_VALID : DAT_DATA_VALID, mv); end
        checks++; if ((w == 0 ? DAT_DATA_VALID : INS_DATA_VALID) !== 1'b0) begin failures++; $display("FAIL other_valid got=1 exp=0"); end
        checks++; if (MEM_RDATA_READY !== rd) begin failures++; $display("FAIL rdata_ready beat=%0d got=%0b exp=%0b", beats, MEM_RDATA_READY, rd); end
        checks++; if (INS_DATA !== d || DAT_DATA !== d) begin failures++; $display("FAIL rdata_pass got=%0h/%0h exp=%0h", INS_DATA, DAT_DATA, d); end
        checks++; if ({DAT_WR_COMPLETE, DAT_WR_READY, MEM_WDATA_VALID, MEM_ADDR_VALID} !== 4'b0)
          begin failures++; $display("FAIL rd_phase_quiet got=%b exp=0000", {DAT_WR_COMPLETE, DAT_WR_READY, MEM_WDATA_VALID, MEM_ADDR_VALID}); end
        if (mv && rd) beats++;
        cyc++;
        tick();
      end
      checks++; if (beats != BURST) begin failures++; $display("FAIL read_timeout beats got=%0d exp=%0d", beats, BURST); end
      MEM_RDATA_VALID = 1; INS_DATA_READY = 1; DAT_DATA_READY = 1; MEM_WR_DONE = 0;
      #1;
      checks++; if ({MEM_RDATA_READY, INS_DATA_VALID, DAT_DATA_VALID, MEM_ADDR_VALID} !== 4'b0)
        begin failures++; $display("FAIL idle_after_read got=%b exp=0000", {MEM_RDATA_READY, INS_DATA_VALID, DAT_DATA_VALID, MEM_ADDR_VALID}); end
      MEM_RDATA_VALID = 0;
    end else begin
      while (beats < BURST && cyc < 200) begin
        mv = (bp == 1) ? 1'($urandom) : 1'b1;
        rd = (bp == 1) ? 1'($urandom) : (bp == 2) ? (cyc % 2 == 0) : 1'b1;
        DAT_WR_VALID = mv; DAT_WR_DATA = wdata[beats]; MEM_WDATA_READY = rd; MEM_WR_DONE = 1'($urandom);
        #1;
        checks++; if (MEM_WDATA_VALID !== mv) begin failures++; $display("FAIL wdata_valid beat=%0d got=%0b exp=%0b", beats, MEM_WDATA_VALID, mv); end
        checks++; if (DAT_WR_READY !== rd) begin failures++; $display("FAIL wr_ready beat=%0d got=%0b exp=%0b", beats, DAT_WR_READY, rd); end
        checks++; if (MEM_WDATA !== wdata[beats]) begin failures++; $display("FAIL wdata beat=%0d got=%0h exp=%0h", beats, MEM_WDATA, wdata[beats]); end
        checks++; if ({DAT_WR_COMPLETE, MEM_RDATA_READY, INS_ADDR_READY, DAT_RD_ADDR_READY} !== 4'b0)
          begin failures++; $display("FAIL wr_phase_quiet got=%b exp=0000", {DAT_WR_COMPLETE, MEM_RDATA_READY, INS_ADDR_READY, DAT_RD_ADDR_READY}); end
        if (mv && rd) beats++;
        cyc++;
        tick();
      end
      checks++; if (beats != BURST) begin failures++; $display("FAIL write_timeout beats got=%0d exp=%0d", beats, BURST); end
      DAT_WR_VALID = 1; MEM_WDATA_READY = 1; MEM_WR_DONE = 0;
      #1;
      checks++; if ({MEM_WDATA_VALID, DAT_WR_READY, DAT_WR_COMPLETE, INS_ADDR_READY, DAT_RD_ADDR_READY} !== 5'b0)
        begin failures++; $display("FAIL wr_wait_quiet got=%b exp=00000", {MEM_WDATA_VALID, DAT_WR_READY, DAT_WR_COMPLETE, INS_ADDR_READY, DAT_RD_ADDR_READY}); end
      pending[2] = 1'b0; DAT_WR_VALID = 0;
      extra = (bp == 1) ? int'($urandom_range(0, 3)) : 2;
      for (int e = 0; e < extra; e++) tick();
      MEM_WR_DONE = 1;
      #1;
      checks++; if (DAT_WR_COMPLETE !== 1'b0) begin failures++; $display("FAIL complete_early got=1 exp=0"); end
      tick();
      MEM_WR_DONE = 0; drive_requests();
      #1;
      checks++; if (DAT_WR_COMPLETE !== 1'b1) begin failures++; $display("FAIL complete_pulse got=%0b exp=1", DAT_WR_COMPLETE); end
      checks++; if (MEM_ADDR_VALID !== 1'b0) begin failures++; $display("FAIL idle_after_write got=%0b exp=0", MEM_ADDR_VALID); end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    INS_ADDR_VALID = 1; DAT_RD_ADDR_VALID = 1; DAT_WR_VALID = 1; MEM_RDATA_VALID = 1;
    MEM_WR_DONE = 1; MEM_ADDR_READY = 1; MEM_WDATA_READY = 1; INS_DATA_READY = 1; DAT_DATA_READY = 1;
    tick(); tick();
    checks++; if ({INS_ADDR_READY, DAT_RD_ADDR_READY, DAT_WR_READY} !== 3'b0) begin failures++; $display("FAIL reset_readies got=%b exp=000", {INS_ADDR_READY, DAT_RD_ADDR_READY, DAT_WR_READY}); end
    checks++; if ({INS_DATA_VALID, DAT_DATA_VALID, MEM_WDATA_VALID, MEM_RDATA_READY} !== 4'b0) begin failures++; $display("FAIL reset_valids got=%b exp=0000", {INS_DATA_VALID, DAT_DATA_VALID, MEM_WDATA_VALID, MEM_RDATA_READY}); end
    checks++; if (MEM_ADDR_VALID !== 1'b0) begin failures++; $display("FAIL reset_addr_valid got=%0b exp=0", MEM_ADDR_VALID); end
    checks++; if (MEM_ADDR !== 30'd0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", MEM_ADDR); end
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", MEM_WE); end
    checks++; if (DAT_WR_COMPLETE !== 1'b0) begin failures++; $display("FAIL reset_complete got=%0b exp=0", DAT_WR_COMPLETE); end
    apply_reset();
  endtask

  task automatic test_ins_read();
    int w;
    apply_reset();
    pending[0] = 1'b1; paddr[0] = 30'h0000_1234;
    run_txn(3'b000, 0, 0, w);
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    for (int n = 0; n < 4; n++) run_txn(3'b111, 0, 0, w);
  endtask

  task automatic test_write_burst();
    int w;
    apply_reset();
    run_txn(3'b100, 2, 0, w);
    tick();
    checks++; if (DAT_WR_COMPLETE !== 1'b0) begin failures++; $display("FAIL complete_width got=%0b exp=0", DAT_WR_COMPLETE); end
  endtask

  task automatic test_read_backpressure();
    int w;
    apply_reset();
    run_txn(3'b001, 3, 0, w);
  endtask

  task automatic test_addr_stall();
    int w;
    apply_reset();
    run_txn(3'b011, 0, 5, w);
    run_txn(3'b000, 0, 0, w);
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    INS_ADDR_VALID = 1; INS_ADDR = 30'h0ABC_DEF0;
    tick();
    INS_ADDR_VALID = 0; MEM_ADDR_READY = 1;
    tick();
    MEM_ADDR_READY = 0; MEM_RDATA_VALID = 1; INS_DATA_READY = 1;
    tick(); tick();
    RST = 1;
    #1;
    checks++; if ({INS_DATA_VALID, MEM_RDATA_READY, MEM_ADDR_VALID, INS_ADDR_READY} !== 4'b0) begin failures++; $display("FAIL mid_reset_outputs got=%b exp=0000", {INS_DATA_VALID, MEM_RDATA_READY, MEM_ADDR_VALID, INS_ADDR_READY}); end
    checks++; if ({MEM_ADDR, MEM_WE} !== 31'd0) begin failures++; $display("FAIL mid_reset_addr got=%0h exp=0", {MEM_ADDR, MEM_WE}); end
    clear_inputs(); pending = '0; model_last = 2;
    tick();
    RST = 0;
    run_txn(3'b010, 0, 0, w);
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 40; n++)
      run_txn(3'($urandom_range(1, 7)), 1, int'($urandom_range(0, 3)), w);
  endtask

  initial begin
    pending = '0;
    for (int i = 0; i < 3; i++) paddr[i] = '0;
    for (int b = 0; b < BURST; b++) wdata[b] = '0;
    test_reset();
    test_ins_read();
    test_round_robin();
    test_write_burst();
    test_read_backpressure();
    test_addr_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
